// File: rtl/isub_rows_engine.sv
// Inverse row shift followed by byte substitution on a 128-bit column-major state, one column per cycle.
// Define ISUB_PIPE_REG_EN to register the four lookup outputs before the result register.
module ISub_byte (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_o = SBOX[a_i];
endmodule

module isub_rows_engine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] data_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef ISUB_PIPE_REG_EN
  localparam int CW = 3;
  localparam logic [CW-1:0] LAST_CNT = CW'(4);
`else
  localparam int CW = 2;
  localparam logic [CW-1:0] LAST_CNT = CW'(3);
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      in_q  [16];
  logic [7:0]      res_q [16];
  logic [7:0]      sb_out [4];
  logic [7:0]      wbyte  [4];
  logic [1:0]      src_col [4];
  logic [1:0]      wcol;
  logic            load;
  logic            busy_wr;
  logic            wr_en;

  // Row r of column c reads input column (c - r) mod 4; 2-bit subtraction gives the wrap for free.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lookup
    assign src_col[gi] = cnt_q[1:0] - 2'(gi);
    ISub_byte u_sb (
      .a_i (in_q[{src_col[gi], 2'(gi)}]),
      .y_o (sb_out[gi])
    );
  end

`ifdef ISUB_PIPE_REG_EN
  logic [7:0] pipe_q [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_q[gi] <= 8'h00;
      end else if (state_q == BUSY) begin
        pipe_q[gi] <= sb_out[gi];
      end
    end
    assign wbyte[gi] = pipe_q[gi];
  end

  // Pipe stage delays each column by one count, so column cnt-1 is written.
  assign wcol  = cnt_q[1:0] - 2'd1;
  assign wr_en = busy_wr && (cnt_q != '0);
`else
  for (genvar gi = 0; gi < 4; gi++) begin : g_nopipe
    assign wbyte[gi] = sb_out[gi];
  end

  assign wcol  = cnt_q[1:0];
  assign wr_en = busy_wr;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    busy_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy_wr = 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_regs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        in_q[gi]  <= 8'h00;
        res_q[gi] <= 8'h00;
      end else begin
        if (load) begin
          in_q[gi] <= data_in[8*gi +: 8];
        end
        if (wr_en && (wcol == 2'(gi / 4))) begin
          res_q[gi] <= wbyte[gi % 4];
        end
      end
    end
    assign data_out[8*gi +: 8] = res_q[gi];
  end
endmodule

// File: tb/tb_isub_rows_engine.sv
// Self-checking bench for isub_rows_engine; reference S-box derived from GF(2^8) inversion plus affine map.
module tb_isub_rows_engine;
`ifdef ISUB_PIPE_REG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] data_out;

  int total = 0;
  int bad   = 0;

  isub_rows_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    if (v != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:127] model(input logic [0:127] st);
    logic [0:127] res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[8*(4*c + r) +: 8] = sbox(st[8*(4*((c - r + 4) % 4) + r) +: 8]);
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept st at the next edge, then check the busy window and the arrival of the result.
  task automatic run_one(input string tag, input logic [0:127] st);
    logic [0:127] exp = model(st);
    in_valid = 1'b1;
    data_in  = st;
    check({tag, "_ready_before"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      data_in = rnd128();
      tick();
      check({tag, "_busy_valid"}, 128'(out_valid), 128'(0));
    end
    tick();
    check({tag, "_valid"}, 128'(out_valid), 128'(1));
    check({tag, "_data"}, data_out, exp);
    $display("txn %s in=%h out=%h", tag, st, data_out);
    tick();
    check({tag, "_back_idle"}, 128'(in_ready & ~out_valid), 128'(1));
  endtask

  initial begin
    logic [0:127] st;
    logic [0:127] st2;
    logic [0:127] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    #12;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_data_out", data_out, 128'(0));
    rst_n = 1'b1;
    #2;
    tick();
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    run_one("zeros", '0);
    check("zeros_all63", data_out, {16{8'h63}});
    st = '0; st[0:7] = 8'h52;
    run_one("b0_52", st);
    check("b0_52_exact", data_out, {8'h00, {15{8'h63}}});
    st = '0; st[8:15] = 8'hff;
    run_one("b1_ff", st);
    check("b1_ff_exact", data_out, {{5{8'h63}}, 8'h16, {10{8'h63}}});

    for (int j = 0; j < 4; j++) run_one("rand", rnd128());

    // Back-to-back stream: one state every LAT+1 cycles, inputs ignored while busy.
    st = rnd128();
    in_valid = 1'b1;
    data_in  = st;
    for (int j = 0; j < 6; j++) begin
      tick();
      for (int c = 1; c < LAT; c++) begin
        data_in = rnd128();
        tick();
        check("b2b_busy_ready", 128'(in_ready), 128'(0));
      end
      data_in = rnd128();
      tick();
      check("b2b_valid", 128'(out_valid), 128'(1));
      check("b2b_data", data_out, model(st));
      check("b2b_ready", 128'(in_ready), 128'(1));
      $display("txn b2b%0d in=%h out=%h", j, st, data_out);
      st = rnd128();
      data_in = st;
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: result held for 10 cycles, then same-cycle accept of the next state.
    out_ready = 1'b0;
    st = rnd128();
    in_valid = 1'b1;
    data_in  = st;
    tick();
    for (int c = 0; c < LAT; c++) begin
      data_in = rnd128();
      tick();
    end
    held = data_out;
    check("bp_first_data", held, model(st));
    for (int c = 0; c < 10; c++) begin
      data_in = rnd128();
      tick();
      check("bp_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_stable", data_out, held);
    end
    st2 = rnd128();
    data_in   = st2;
    out_ready = 1'b1;
    #1;
    check("bp_ready_follows", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("bp_accepted", 128'(out_valid), 128'(0));
    for (int c = 1; c < LAT; c++) tick();
    tick();
    check("bp_next_valid", 128'(out_valid), 128'(1));
    check("bp_next_data", data_out, model(st2));
    $display("txn bp in=%h out=%h", st2, data_out);
    tick();

    // Reset in the middle of BUSY (column 2) discards the in-flight state.
    in_valid = 1'b1;
    data_in  = rnd128();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_data", data_out, 128'(0));
    check("mid_rst_ready", 128'(in_ready), 128'(1));
    #6;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("post_rst_no_valid", 128'(out_valid), 128'(0));
      check("post_rst_ready", 128'(in_ready), 128'(1));
      check("post_rst_data", data_out, 128'(0));
    end
    run_one("after_rst", rnd128());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
